// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared definitions for the systolic tile sequencer: state encoding,
// buffer read latency and the expected result-count helper.
package systolic_tile_sequencer_pkg;

  localparam int CNT_W = 16;

  // State encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WFETCH = 3'd1;
  localparam logic [2:0] ST_WLOAD  = 3'd2;
  localparam logic [2:0] ST_WGAP   = 3'd3;
  localparam logic [2:0] ST_START  = 3'd4;
  localparam logic [2:0] ST_ACT    = 3'd5;
  localparam logic [2:0] ST_WAIT   = 3'd6;
  localparam logic [2:0] ST_RESP   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_WFETCH = ST_WFETCH,
    S_WLOAD  = ST_WLOAD,
    S_WGAP   = ST_WGAP,
    S_START  = ST_START,
    S_ACT    = ST_ACT,
    S_WAIT   = ST_WAIT,
    S_RESP   = ST_RESP
  } state_t;

  // Weight/activation buffers return data this many cycles after the read.
  localparam int BUF_RD_LATENCY = 1;

  // Result vectors the array produces for K activations on an N x N tile:
  // skew/drain gives 3N-2 vectors, plus one per activation beyond 3N-3.
  function automatic logic [CNT_W-1:0] result_count(input logic [CNT_W-1:0] k_tiles,
                                                    input int unsigned n);
    int unsigned skew;
    int unsigned extra;
    skew  = 3 * n - 3;
    extra = (int'(k_tiles) > int'(skew)) ? (int'(k_tiles) - skew) : 0;
    return CNT_W'(extra + (3 * n - 2));
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer_if.sv
// Command/response channel between a host and the tile sequencer.
interface systolic_tile_sequencer_if
  import systolic_tile_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_load_weights;
  logic                  cmd_clear_acc;
  logic [CNT_W-1:0]      cmd_k_tiles;
  logic [ADDR_WIDTH-1:0] cmd_w_base;
  logic [ADDR_WIDTH-1:0] cmd_act_base;
  logic [ADDR_WIDTH-1:0] cmd_res_base;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_err;
  logic [CNT_W-1:0]      rsp_count;

  modport master (
    output cmd_valid, cmd_load_weights, cmd_clear_acc, cmd_k_tiles,
           cmd_w_base, cmd_act_base, cmd_res_base, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_count
  );

  modport slave (
    input  cmd_valid, cmd_load_weights, cmd_clear_acc, cmd_k_tiles,
           cmd_w_base, cmd_act_base, cmd_res_base, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_count
  );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Runs one tile operation on a weight-stationary systolic array: optional
// weight fetch/load, activation streaming, result write-back and response.
module systolic_tile_sequencer
  import systolic_tile_sequencer_pkg::*;
#(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
  localparam int VEC_W = ARRAY_SIZE * DATA_WIDTH,
  localparam int RES_W = ARRAY_SIZE * ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_tile_sequencer_if.slave host,
  output logic                  wbuf_rd_en_o,
  output logic [ADDR_WIDTH-1:0] wbuf_rd_addr_o,
  input  logic [VEC_W-1:0]      wbuf_rd_data_i,
  output logic                  abuf_rd_en_o,
  output logic [ADDR_WIDTH-1:0] abuf_rd_addr_o,
  input  logic [VEC_W-1:0]      abuf_rd_data_i,
  output logic                  res_wr_en_o,
  output logic [ADDR_WIDTH-1:0] res_wr_addr_o,
  output logic [RES_W-1:0]      res_wr_data_o,
  output logic                  sa_start_o,
  output logic                  sa_clear_acc_o,
  output logic [CNT_W-1:0]      sa_k_tiles_o,
  output logic                  sa_weight_load_en_o,
  output logic [COL_W-1:0]      sa_weight_load_col_o,
  output logic [VEC_W-1:0]      sa_weight_load_data_o,
  output logic                  sa_act_valid_o,
  output logic [VEC_W-1:0]      sa_act_data_o,
  input  logic                  sa_act_ready_i,
  input  logic                  sa_busy_i,
  input  logic                  sa_done_i,
  input  logic                  sa_result_valid_i,
  input  logic [RES_W-1:0]      sa_result_data_i,
  output logic                  sa_result_ready_o
);

  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(ARRAY_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] RD_AHEAD = ADDR_WIDTH'(BUF_RD_LATENCY);

  state_t                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  clear_q;
  logic [CNT_W-1:0]      k_q;
  logic [ADDR_WIDTH-1:0] w_base_q, act_base_q, res_base_q;
  logic                  accept;
  logic                  unused_s;

  // The array's busy flag is informational; completion is taken from sa_done.
  assign unused_s = sa_busy_i;

  assign accept            = (state_q == S_IDLE) && host.cmd_valid;
  assign sa_result_ready_o = 1'b1;
  assign sa_k_tiles_o      = k_q;
  assign sa_clear_acc_o    = clear_q;
  assign host.rsp_err      = err_q;
  assign host.rsp_count    = cnt_q;

  // State, counters and latched command fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      clear_q    <= 1'b0;
      k_q        <= '0;
      w_base_q   <= '0;
      act_base_q <= '0;
      res_base_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        clear_q    <= host.cmd_clear_acc;
        k_q        <= host.cmd_k_tiles;
        w_base_q   <= host.cmd_w_base;
        act_base_q <= host.cmd_act_base;
        res_base_q <= host.cmd_res_base;
      end
    end
  end

  // Next-state decode, per-state buffer/array controls and result capture
  always_comb begin
    state_d               = state_q;
    col_d                 = col_q;
    idx_d                 = idx_q;
    cnt_d                 = cnt_q;
    err_d                 = err_q;
    host.cmd_ready        = 1'b0;
    host.rsp_valid        = 1'b0;
    wbuf_rd_en_o          = 1'b0;
    wbuf_rd_addr_o        = '0;
    abuf_rd_en_o          = 1'b0;
    abuf_rd_addr_o        = '0;
    sa_start_o            = 1'b0;
    sa_weight_load_en_o   = 1'b0;
    sa_weight_load_col_o  = '0;
    sa_weight_load_data_o = '0;
    sa_act_valid_o        = 1'b0;
    sa_act_data_o         = '0;
    res_wr_en_o           = 1'b0;
    res_wr_addr_o         = '0;
    res_wr_data_o         = '0;

    case (state_q)
      S_IDLE: begin
        host.cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          col_d = '0;
          idx_d = '0;
          if (host.cmd_k_tiles == 16'd0) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = host.cmd_load_weights ? S_WFETCH : S_START;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WFETCH: begin
        wbuf_rd_en_o   = 1'b1;
        wbuf_rd_addr_o = w_base_q;
        state_d        = S_WLOAD;
      end
      S_WLOAD: begin
        sa_weight_load_en_o   = 1'b1;
        sa_weight_load_col_o  = col_q;
        sa_weight_load_data_o = wbuf_rd_data_i;
        sa_start_o            = (col_q == '0);
        if (col_q != LAST_COL) begin
          wbuf_rd_en_o   = 1'b1;
          wbuf_rd_addr_o = w_base_q + ADDR_WIDTH'(col_q) + RD_AHEAD;
          col_d          = col_q + COL_W'(1);
        end else begin
          state_d = S_WGAP;
        end
      end
      S_WGAP: begin
        abuf_rd_en_o   = 1'b1;
        abuf_rd_addr_o = act_base_q;
        state_d        = S_ACT;
      end
      S_START: begin
        sa_start_o     = 1'b1;
        abuf_rd_en_o   = 1'b1;
        abuf_rd_addr_o = act_base_q;
        state_d        = S_ACT;
      end
      S_ACT: begin
        sa_act_valid_o = 1'b1;
        sa_act_data_o  = abuf_rd_data_i;
        if (!sa_act_ready_i) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (idx_q != (k_q - 16'd1)) begin
          abuf_rd_en_o   = 1'b1;
          abuf_rd_addr_o = act_base_q + ADDR_WIDTH'(idx_q) + RD_AHEAD;
          idx_d          = idx_q + 16'd1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sa_done_i) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        host.rsp_valid = 1'b1;
        if (host.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Results stream straight through to the result buffer outside IDLE.
    if (accept) begin
      cnt_d = '0;
    end else if ((state_q != S_IDLE) && sa_result_valid_i) begin
      res_wr_en_o   = 1'b1;
      res_wr_addr_o = res_base_q + ADDR_WIDTH'(cnt_q);
      res_wr_data_o = sa_result_data_i;
      cnt_d         = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Self-checking bench: behavioural array and buffers, scoreboard of
// expected result-buffer writes computed from a golden matmul.
module tb_systolic_tile_sequencer;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int VW = N * DW;
  localparam int RW = N * AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_tile_sequencer_if #(.ADDR_WIDTH(16)) host_if ();

  logic          wbuf_rd_en, abuf_rd_en, res_wr_en;
  logic [15:0]   wbuf_rd_addr, abuf_rd_addr, res_wr_addr;
  logic [VW-1:0] wbuf_rd_data, abuf_rd_data;
  logic [RW-1:0] res_wr_data;
  logic          sa_start, sa_clear_acc, sa_weight_load_en, sa_act_valid;
  logic [15:0]   sa_k_tiles;
  logic [1:0]    sa_weight_load_col;
  logic [VW-1:0] sa_weight_load_data, sa_act_data;
  logic          sa_act_ready, sa_busy, sa_done, sa_result_valid, sa_result_ready;
  logic [RW-1:0] sa_result_data;

  systolic_tile_sequencer #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .host(host_if.slave),
    .wbuf_rd_en_o(wbuf_rd_en), .wbuf_rd_addr_o(wbuf_rd_addr), .wbuf_rd_data_i(wbuf_rd_data),
    .abuf_rd_en_o(abuf_rd_en), .abuf_rd_addr_o(abuf_rd_addr), .abuf_rd_data_i(abuf_rd_data),
    .res_wr_en_o(res_wr_en), .res_wr_addr_o(res_wr_addr), .res_wr_data_o(res_wr_data),
    .sa_start_o(sa_start), .sa_clear_acc_o(sa_clear_acc), .sa_k_tiles_o(sa_k_tiles),
    .sa_weight_load_en_o(sa_weight_load_en), .sa_weight_load_col_o(sa_weight_load_col),
    .sa_weight_load_data_o(sa_weight_load_data), .sa_act_valid_o(sa_act_valid),
    .sa_act_data_o(sa_act_data), .sa_act_ready_i(sa_act_ready), .sa_busy_i(sa_busy),
    .sa_done_i(sa_done), .sa_result_valid_i(sa_result_valid), .sa_result_data_i(sa_result_data),
    .sa_result_ready_o(sa_result_ready)
  );

  // Buffers
  logic [VW-1:0] wmem [0:255];
  logic [VW-1:0] amem [0:255];

  // One-cycle-latency buffer reads
  always @(posedge clk) begin
    if (wbuf_rd_en) wbuf_rd_data <= wmem[wbuf_rd_addr[7:0]];
    if (abuf_rd_en) abuf_rd_data <= amem[abuf_rd_addr[7:0]];
  end

  // Behavioural array: captures weights, collects K activations, then emits results
  logic [VW-1:0] m_w [0:N-1];
  logic [VW-1:0] m_act [0:63];
  logic          m_run, m_emit;
  logic [15:0]   m_k, m_nact, m_ei, m_cnt;

  assign sa_act_ready = m_run && !m_emit;
  assign sa_busy      = m_run;

  function automatic logic [RW-1:0] model_mac(input logic [VW-1:0] a);
    logic [RW-1:0] r;
    logic [31:0]   acc;
    for (int c = 0; c < N; c++) begin
      acc = 32'd0;
      for (int e = 0; e < N; e++) acc = acc + 32'(m_w[c][e*DW +: DW]) * 32'(a[e*DW +: DW]);
      r[c*AW +: AW] = acc;
    end
    return r;
  endfunction

  // Array model sequencing
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_emit <= 1'b0; m_k <= 16'd0; m_nact <= 16'd0; m_ei <= 16'd0; m_cnt <= 16'd0;
      sa_result_valid <= 1'b0; sa_result_data <= '0; sa_done <= 1'b0;
      for (int c = 0; c < N; c++) m_w[c] <= '0;
    end else begin
      sa_result_valid <= 1'b0; sa_result_data <= '0; sa_done <= 1'b0;
      if (sa_weight_load_en) m_w[sa_weight_load_col] <= sa_weight_load_data;
      if (sa_start) begin
        m_run <= 1'b1; m_emit <= 1'b0; m_k <= sa_k_tiles; m_nact <= 16'd0; m_ei <= 16'd0;
      end else if (m_run && !m_emit) begin
        if (sa_act_valid) begin
          m_act[m_nact[5:0]] <= sa_act_data;
          m_nact <= m_nact + 16'd1;
        end
        if (m_nact == m_k) begin
          m_emit <= 1'b1; m_ei <= 16'd0;
          m_cnt <= (m_k > 16'd9) ? m_k + 16'd1 : 16'd10;
        end
      end else if (m_emit) begin
        if (m_ei < m_cnt) begin
          sa_result_valid <= 1'b1;
          sa_result_data  <= (m_ei < m_k) ? model_mac(m_act[m_ei[5:0]]) : '0;
          m_ei <= m_ei + 16'd1;
        end else begin
          sa_done <= 1'b1; m_emit <= 1'b0; m_run <= 1'b0;
        end
      end
    end
  end

  // Monitor: record writes and weight reads, count array strobes
  logic [143:0] act_q[$];
  logic [15:0]  wrd_q[$];
  int n_actv = 0, n_start = 0, n_start_col0 = 0;
  always @(negedge clk) begin
    if (res_wr_en) act_q.push_back({res_wr_addr, res_wr_data});
    if (wbuf_rd_en) wrd_q.push_back(wbuf_rd_addr);
    if (sa_act_valid) n_actv <= n_actv + 1;
    if (sa_start) n_start <= n_start + 1;
    if (sa_start && sa_weight_load_en && sa_weight_load_col == 2'd0) n_start_col0 <= n_start_col0 + 1;
  end

  logic [143:0] exp_q[$];
  int act_rd = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [RW-1:0] golden(input logic [15:0] wb, input logic [15:0] aa);
    logic [RW-1:0] r;
    logic [31:0]   acc;
    logic [15:0]   wa;
    logic [VW-1:0] a, w;
    a = amem[aa[7:0]];
    for (int c = 0; c < N; c++) begin
      wa = wb + 16'(c);
      w = wmem[wa[7:0]];
      acc = 32'd0;
      for (int e = 0; e < N; e++) acc = acc + 32'(w[e*DW +: DW]) * 32'(a[e*DW +: DW]);
      r[c*AW +: AW] = acc;
    end
    return r;
  endfunction

  task automatic push_expected(input logic [15:0] k, input logic [15:0] wb,
                               input logic [15:0] ab, input logic [15:0] rb);
    int cnt;
    logic [RW-1:0] d;
    cnt = (int'(k) > 9) ? int'(k) + 1 : 10;
    for (int j = 0; j < cnt; j++) begin
      d = (j < int'(k)) ? golden(wb, ab + 16'(j)) : '0;
      exp_q.push_back({rb + 16'(j), d});
    end
  endtask

  task automatic set_cmd(input logic lw, input logic clr, input logic [15:0] k,
                         input logic [15:0] wb, input logic [15:0] ab, input logic [15:0] rb);
    host_if.cmd_load_weights = lw; host_if.cmd_clear_acc = clr; host_if.cmd_k_tiles = k;
    host_if.cmd_w_base = wb; host_if.cmd_act_base = ab; host_if.cmd_res_base = rb;
    host_if.cmd_valid = 1'b1;
  endtask

  task automatic issue_cmd(input logic lw, input logic clr, input logic [15:0] k, input logic [15:0] wb,
                           input logic [15:0] ab, input logic [15:0] rb, output logic ok);
    @(negedge clk);
    set_cmd(lw, clr, k, wb, ab, rb);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) if (!ok) begin
      if (host_if.cmd_ready) ok = 1'b1; else @(negedge clk);
    end
    @(posedge clk); #1;
    host_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic ok, output logic err, output logic [15:0] cnt);
    ok = 1'b0; err = 1'b0; cnt = 16'd0;
    for (int t = 0; t < 2000; t++) if (!ok) begin
      @(negedge clk);
      if (host_if.rsp_valid) begin ok = 1'b1; err = host_if.rsp_err; cnt = host_if.rsp_count; end
    end
    if (ok) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total_cnt++;
    if ({host_if.cmd_ready, sa_result_ready} !== 2'b11) $display("FAIL reset_ready got=%b want=11", {host_if.cmd_ready, sa_result_ready});
    else pass_cnt++;
    total_cnt++;
    if (|{wbuf_rd_en, wbuf_rd_addr, abuf_rd_en, abuf_rd_addr, res_wr_en, res_wr_addr, res_wr_data, sa_start,
          sa_clear_acc, sa_k_tiles, sa_weight_load_en, sa_weight_load_col, sa_weight_load_data, sa_act_valid,
          sa_act_data, host_if.rsp_valid, host_if.rsp_err, host_if.rsp_count} !== 1'b0)
      $display("FAIL reset_outputs got=nonzero want=0");
    else pass_cnt++;
  endtask

  task automatic test_load_compute();
    int a0, w0, s0, c0, v0; logic ok, err; logic [15:0] cnt; logic addr_ok;
    logic [143:0] e, a;
    a0 = act_q.size(); w0 = wrd_q.size(); s0 = n_start; c0 = n_start_col0; v0 = n_actv;
    push_expected(16'd4, 16'h0010, 16'h0020, 16'h0040);
    issue_cmd(1'b1, 1'b1, 16'd4, 16'h0010, 16'h0020, 16'h0040, ok);
    total_cnt++; if (!ok) $display("FAIL load_accept got=0 want=1"); else pass_cnt++;
    total_cnt++;
    if ({sa_k_tiles, sa_clear_acc} !== {16'd4, 1'b1}) $display("FAIL load_cfg got=%h want=%h", {sa_k_tiles, sa_clear_acc}, {16'd4, 1'b1});
    else pass_cnt++;
    wait_rsp(ok, err, cnt);
    total_cnt++;
    if ({ok, err, cnt} !== {1'b1, 1'b0, 16'd10}) $display("FAIL load_rsp got=%b/%b/%0d want=1/0/10", ok, err, cnt);
    else pass_cnt++;
    addr_ok = (wrd_q.size() - w0 == 4);
    for (int i = 0; i < 4; i++) if (addr_ok && wrd_q[w0 + i] !== 16'h0010 + 16'(i)) addr_ok = 1'b0;
    total_cnt++;
    if (addr_ok !== 1'b1) $display("FAIL load_wbuf_reads got=%0d reads want=4 at 0x10..0x13", wrd_q.size() - w0);
    else pass_cnt++;
    total_cnt++;
    if ({n_start - s0, n_start_col0 - c0} !== {32'd1, 32'd1}) $display("FAIL load_start got=%0d,%0d want=1,1", n_start - s0, n_start_col0 - c0);
    else pass_cnt++;
    total_cnt++;
    if (n_actv - v0 !== 4) $display("FAIL load_act_valid got=%0d want=4", n_actv - v0); else pass_cnt++;
    total_cnt++;
    if (act_q.size() - a0 !== 10) $display("FAIL load_nwrites got=%0d want=10", act_q.size() - a0); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_rd < act_q.size()) ? act_q[act_rd] : 'x;
      act_rd++;
      total_cnt++;
      if (a !== e) $display("FAIL load_write got=%h want=%h", a, e); else pass_cnt++;
    end
    act_rd = act_q.size();
  endtask

  task automatic test_weight_reuse();
    int a0, w0, v0; logic ok, err; logic [15:0] cnt;
    logic [143:0] e, a;
    a0 = act_q.size(); w0 = wrd_q.size(); v0 = n_actv;
    push_expected(16'd12, 16'h0010, 16'h0080, 16'h0060);
    issue_cmd(1'b0, 1'b1, 16'd12, 16'h00F0, 16'h0080, 16'h0060, ok);
    wait_rsp(ok, err, cnt);
    total_cnt++;
    if ({ok, err, cnt} !== {1'b1, 1'b0, 16'd13}) $display("FAIL reuse_rsp got=%b/%b/%0d want=1/0/13", ok, err, cnt);
    else pass_cnt++;
    total_cnt++;
    if (wrd_q.size() - w0 !== 0) $display("FAIL reuse_wbuf_reads got=%0d want=0", wrd_q.size() - w0); else pass_cnt++;
    total_cnt++;
    if ({act_q.size() - a0, n_actv - v0} !== {32'd13, 32'd12}) $display("FAIL reuse_counts got=%0d,%0d want=13,12", act_q.size() - a0, n_actv - v0);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_rd < act_q.size()) ? act_q[act_rd] : 'x;
      act_rd++;
      total_cnt++;
      if (a !== e) $display("FAIL reuse_write got=%h want=%h", a, e); else pass_cnt++;
    end
    act_rd = act_q.size();
  endtask

  task automatic test_k_zero();
    int a0, s0, lat; logic ok, err; logic [15:0] cnt;
    a0 = act_q.size(); s0 = n_start;
    issue_cmd(1'b1, 1'b0, 16'd0, 16'h0010, 16'h0020, 16'h0500, ok);
    lat = 1;
    while (!host_if.rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    total_cnt++;
    if (lat > 2) $display("FAIL kzero_latency got=%0d want<=2", lat); else pass_cnt++;
    wait_rsp(ok, err, cnt);
    total_cnt++;
    if ({ok, err, cnt} !== {1'b1, 1'b1, 16'd0}) $display("FAIL kzero_rsp got=%b/%b/%0d want=1/1/0", ok, err, cnt);
    else pass_cnt++;
    total_cnt++;
    if ({n_start - s0, act_q.size() - a0} !== {32'd0, 32'd0}) $display("FAIL kzero_activity got=%0d,%0d want=0,0", n_start - s0, act_q.size() - a0);
    else pass_cnt++;
    act_rd = act_q.size();
  endtask

  task automatic test_back_to_back();
    logic ok, err, seen; logic [15:0] cnt, cnt0;
    logic [143:0] e, a;
    host_if.rsp_ready = 1'b0;
    push_expected(16'd2, 16'h0010, 16'h0030, 16'h0100);
    issue_cmd(1'b0, 1'b0, 16'd2, 16'h0000, 16'h0030, 16'h0100, ok);
    seen = 1'b0;
    for (int t = 0; t < 500; t++) if (!seen) begin @(negedge clk); seen = host_if.rsp_valid; end
    cnt0 = host_if.rsp_count;
    total_cnt++;
    if ({seen, cnt0} !== {1'b1, 16'd10}) $display("FAIL b2b_first_rsp got=%b/%0d want=1/10", seen, cnt0); else pass_cnt++;
    push_expected(16'd3, 16'h0010, 16'h0040, 16'h0200);
    set_cmd(1'b0, 1'b1, 16'd3, 16'h0000, 16'h0040, 16'h0200);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      total_cnt++;
      if ({host_if.rsp_valid, host_if.rsp_count, host_if.cmd_ready} !== {1'b1, 16'd10, 1'b0})
        $display("FAIL b2b_hold got=%b/%0d/%b want=1/10/0", host_if.rsp_valid, host_if.rsp_count, host_if.cmd_ready);
      else pass_cnt++;
    end
    host_if.rsp_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({host_if.cmd_ready, host_if.rsp_valid} !== 2'b10) $display("FAIL b2b_release got=%b want=10", {host_if.cmd_ready, host_if.rsp_valid});
    else pass_cnt++;
    @(posedge clk); #1;
    host_if.cmd_valid = 1'b0;
    total_cnt++;
    if ({host_if.cmd_ready, sa_k_tiles} !== {1'b0, 16'd3}) $display("FAIL b2b_accept got=%b/%0d want=0/3", host_if.cmd_ready, sa_k_tiles);
    else pass_cnt++;
    wait_rsp(ok, err, cnt);
    total_cnt++;
    if ({ok, err, cnt} !== {1'b1, 1'b0, 16'd10}) $display("FAIL b2b_second_rsp got=%b/%b/%0d want=1/0/10", ok, err, cnt);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_rd < act_q.size()) ? act_q[act_rd] : 'x;
      act_rd++;
      total_cnt++;
      if (a !== e) $display("FAIL b2b_write got=%h want=%h", a, e); else pass_cnt++;
    end
    act_rd = act_q.size();
  endtask

  task automatic test_reset_mid_op();
    logic ok, err, seen; logic [15:0] cnt;
    logic [143:0] e, a;
    issue_cmd(1'b1, 1'b1, 16'd8, 16'h0030, 16'h0090, 16'h0300, ok);
    seen = 1'b0;
    for (int t = 0; t < 100; t++) if (!seen) begin @(negedge clk); seen = sa_act_valid; end
    total_cnt++;
    if (seen !== 1'b1) $display("FAIL rstmid_reach_act got=0 want=1"); else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({host_if.cmd_ready, sa_result_ready} !== 2'b11) $display("FAIL rstmid_ready got=%b want=11", {host_if.cmd_ready, sa_result_ready});
    else pass_cnt++;
    total_cnt++;
    if (|{wbuf_rd_en, wbuf_rd_addr, abuf_rd_en, abuf_rd_addr, res_wr_en, res_wr_addr, res_wr_data, sa_start,
          sa_clear_acc, sa_k_tiles, sa_weight_load_en, sa_weight_load_col, sa_weight_load_data, sa_act_valid,
          sa_act_data, host_if.rsp_valid, host_if.rsp_err, host_if.rsp_count} !== 1'b0)
      $display("FAIL rstmid_outputs got=nonzero want=0");
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    act_rd = act_q.size();
    push_expected(16'd5, 16'h0030, 16'h00A0, 16'h0400);
    issue_cmd(1'b1, 1'b1, 16'd5, 16'h0030, 16'h00A0, 16'h0400, ok);
    wait_rsp(ok, err, cnt);
    total_cnt++;
    if ({ok, err, cnt} !== {1'b1, 1'b0, 16'd10}) $display("FAIL rstmid_after_rsp got=%b/%b/%0d want=1/0/10", ok, err, cnt);
    else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_rd < act_q.size()) ? act_q[act_rd] : 'x;
      act_rd++;
      total_cnt++;
      if (a !== e) $display("FAIL rstmid_write got=%h want=%h", a, e); else pass_cnt++;
    end
    act_rd = act_q.size();
  endtask

  task automatic test_addr_wrap();
    int a0; logic ok, err; logic [15:0] cnt;
    logic [143:0] e, a;
    logic [47:0] got3;
    a0 = act_q.size();
    push_expected(16'd4, 16'h0030, 16'h0020, 16'hFFFE);
    issue_cmd(1'b0, 1'b1, 16'd4, 16'h0000, 16'h0020, 16'hFFFE, ok);
    wait_rsp(ok, err, cnt);
    total_cnt++;
    if ({ok, err, cnt} !== {1'b1, 1'b0, 16'd10}) $display("FAIL wrap_rsp got=%b/%b/%0d want=1/0/10", ok, err, cnt);
    else pass_cnt++;
    got3 = (act_q.size() - a0 >= 3) ? {act_q[a0][143:128], act_q[a0+1][143:128], act_q[a0+2][143:128]} : 'x;
    total_cnt++;
    if (got3 !== 48'hFFFE_FFFF_0000) $display("FAIL wrap_addr got=%h want=fffeffff0000", got3); else pass_cnt++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (act_rd < act_q.size()) ? act_q[act_rd] : 'x;
      act_rd++;
      total_cnt++;
      if (a !== e) $display("FAIL wrap_write got=%h want=%h", a, e); else pass_cnt++;
    end
    act_rd = act_q.size();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      wmem[i] = $urandom();
      amem[i] = $urandom();
    end
    host_if.cmd_valid = 1'b0; host_if.cmd_load_weights = 1'b0; host_if.cmd_clear_acc = 1'b0;
    host_if.cmd_k_tiles = 16'd0; host_if.cmd_w_base = 16'd0; host_if.cmd_act_base = 16'd0;
    host_if.cmd_res_base = 16'd0; host_if.rsp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    test_load_compute();
    test_weight_reuse();
    test_k_zero();
    test_back_to_back();
    test_reset_mid_op();
    test_addr_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=completion");
    $fatal(1, "bench timed out");
  end

endmodule
